// File: rtl/afifo_wr_packer_if.sv
// Beat-source and FIFO-write signal bundle for afifo_wr_packer.
// master = packer side, slave = source/FIFO side.
interface afifo_wr_packer_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned RATIO = 4,
    parameter int unsigned LW    = (RATIO == 8) ? 3 : (RATIO == 4) ? 2 : 1,
    parameter int unsigned FW    = 1 + LW + IN_W * RATIO
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            in_last;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [FW-1:0]   fifo_wr_data;

    modport master (
        input  in_valid, in_data, in_last, fifo_full,
        output in_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        output in_valid, in_data, in_last, fifo_full,
        input  in_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/afifo_wr_packer.sv
// Write-side packer for the async FIFO: gathers RATIO narrow beats into one tagged
// FIFO word, flushing partials on in_last or idle timeout, never pushing while full.
module afifo_wr_packer #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned RATIO = 4,
    parameter int unsigned LW    = (RATIO == 8) ? 3 : (RATIO == 4) ? 2 : 1,
    parameter int unsigned TMO   = 16,
    parameter int unsigned FW    = 1 + LW + IN_W * RATIO
) (
    input  logic              wr_clk,
    input  logic              wr_reset_n,
    afifo_wr_packer_if.master bus,
    output logic              busy,
    output logic [15:0]       word_cnt
);
    localparam int unsigned   TW        = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_T     = TW'(TMO);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [RATIO-1:0][IN_W-1:0] acc;
    logic [RATIO-1:0][IN_W-1:0] acc_merged;
    logic [LW-1:0]              lane_cnt;
    logic [TW-1:0]              idle_tmr;
    logic                       stg_valid;
    logic [FW-1:0]              stg_word;
    logic                       stg_free;
    logic                       tmo_fire;
    logic                       accept;
    logic                       close;

    always_comb begin
        bus.fifo_wr_en   = stg_valid & ~bus.fifo_full;
        bus.fifo_wr_data = stg_word;
        stg_free         = ~stg_valid | bus.fifo_wr_en;
        tmo_fire         = (TMO != 0) && (idle_tmr == TMO_T) && (lane_cnt != '0) && stg_free;
        bus.in_ready     = stg_free & ~tmo_fire;
        accept           = bus.in_valid & bus.in_ready;
        close            = accept & ((lane_cnt == LAST_LANE) | bus.in_last);
        busy             = (lane_cnt != '0) | stg_valid;
        acc_merged           = acc;
        acc_merged[lane_cnt] = bus.in_data;
    end

    always_ff @(posedge wr_clk or negedge wr_reset_n) begin
        if (!wr_reset_n) begin
            acc       <= '0;
            lane_cnt  <= '0;
            idle_tmr  <= '0;
            stg_valid <= 1'b0;
            stg_word  <= '0;
            word_cnt  <= '0;
        end else begin
            // A load always wins over the pop: the outgoing word leaves via fifo_wr_en
            // on the same edge, so staging stays occupied without a bubble.
            if (close) begin
                stg_valid <= 1'b1;
                stg_word  <= {bus.in_last, lane_cnt, acc_merged};
                acc       <= '0;
                lane_cnt  <= '0;
            end else if (tmo_fire) begin
                stg_valid <= 1'b1;
                stg_word  <= {1'b0, LW'(lane_cnt - 1'b1), acc};
                acc       <= '0;
                lane_cnt  <= '0;
            end else begin
                if (bus.fifo_wr_en)
                    stg_valid <= 1'b0;
                if (accept) begin
                    acc      <= acc_merged;
                    lane_cnt <= lane_cnt + 1'b1;
                end
            end

            if ((lane_cnt == '0) || accept || tmo_fire)
                idle_tmr <= '0;
            else if (idle_tmr != TMO_T)
                idle_tmr <= idle_tmr + 1'b1;

            if (bus.fifo_wr_en && (word_cnt != '1))
                word_cnt <= word_cnt + 16'd1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_reset_n)
            assert (!(bus.fifo_wr_en && bus.fifo_full));
    end
endmodule

// File: tb/tb_afifo_wr_packer.sv
// Directed and randomized checks of afifo_wr_packer (IN_W=8, RATIO=4, TMO=16)
// against a beat-list reference model.
module tb_afifo_wr_packer;
    logic        wr_clk = 1'b0;
    logic        wr_reset_n;
    logic        busy;
    logic [15:0] word_cnt;

    int n_cmp = 0;
    int n_err = 0;

    afifo_wr_packer_if #(.IN_W(8), .RATIO(4)) bus ();

    afifo_wr_packer #(.IN_W(8), .RATIO(4), .TMO(16)) dut (
        .wr_clk     (wr_clk),
        .wr_reset_n (wr_reset_n),
        .bus        (bus),
        .busy       (busy),
        .word_cnt   (word_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input bit last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        #1;
        check("beat_ready", 64'(bus.in_ready), 64'd1);
        @(posedge wr_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    function automatic logic [34:0] pack_q(input logic [7:0] q[$], input bit last);
        logic [31:0] d = '0;
        for (int k = 0; k < q.size(); k++)
            d = d | (32'(q[k]) << (8 * k));
        return {last, 2'(q.size() - 1), d};
    endfunction

    initial begin
        logic [7:0]  b[8];
        logic [7:0]  q[$];
        int          push_t[$];
        logic [34:0] push_d[$];
        logic [34:0] staged_word;
        bit          staged;
        int          nonacc;
        int          model_cnt;
        bit          v, f, l, exp_ready, exp_wen;
        logic [7:0]  d;

        wr_reset_n    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.fifo_full = 1'b0;
        #1;
        check("rst_ready", 64'(bus.in_ready), 64'd1);
        check("rst_wen", 64'(bus.fifo_wr_en), 64'd0);
        check("rst_data", 64'(bus.fifo_wr_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt", 64'(word_cnt), 64'd0);
        clk1();
        wr_reset_n = 1'b1;
        clk1();

        // Full word, no last
        beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
        check("t1_wen", 64'(bus.fifo_wr_en), 64'd1);
        check("t1_data", 64'(bus.fifo_wr_data), 64'({1'b0, 2'b11, 32'h44332211}));
        clk1();
        check("t1_wen_off", 64'(bus.fifo_wr_en), 64'd0);
        check("t1_cnt", 64'(word_cnt), 64'd1);

        // Short packet closed by last
        beat(8'hAA, 0); beat(8'hBB, 1);
        check("t2_wen", 64'(bus.fifo_wr_en), 64'd1);
        check("t2_data", 64'(bus.fifo_wr_data), 64'({1'b1, 2'b01, 32'h0000BBAA}));
        clk1();
        check("t2_cnt", 64'(word_cnt), 64'd2);

        // Backpressure from full
        bus.fifo_full = 1'b1;
        beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_wen", 64'(bus.fifo_wr_en), 64'd0);
            check("t3_hold_ready", 64'(bus.in_ready), 64'd0);
            check("t3_hold_data", 64'(bus.fifo_wr_data), 64'({1'b0, 2'b11, 32'h04030201}));
            clk1();
        end
        bus.fifo_full = 1'b0;
        #1;
        check("t3_rel_wen", 64'(bus.fifo_wr_en), 64'd1);
        check("t3_rel_ready", 64'(bus.in_ready), 64'd1);
        clk1();
        check("t3_cnt", 64'(word_cnt), 64'd3);
        check("t3_wen_off", 64'(bus.fifo_wr_en), 64'd0);

        // Idle timeout flush of a single-lane partial
        beat(8'h5A, 0);
        for (int i = 0; i < 16; i++) begin
            check("t4_wait_ready", 64'(bus.in_ready), 64'd1);
            check("t4_wait_wen", 64'(bus.fifo_wr_en), 64'd0);
            clk1();
        end
        check("t4_fire_ready", 64'(bus.in_ready), 64'd0);
        check("t4_fire_busy", 64'(busy), 64'd1);
        clk1();
        check("t4_wen", 64'(bus.fifo_wr_en), 64'd1);
        check("t4_data", 64'(bus.fifo_wr_data), 64'({1'b0, 2'b00, 32'h0000005A}));
        clk1();
        check("t4_cnt", 64'(word_cnt), 64'd4);
        check("t4_idle_busy", 64'(busy), 64'd0);

        // Eight back-to-back beats
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            bus.in_last  = 1'b0;
            #1;
            check("t5_ready", 64'(bus.in_ready), 64'd1);
            if (bus.fifo_wr_en) begin
                push_t.push_back(i);
                push_d.push_back(bus.fifo_wr_data);
            end
            @(posedge wr_clk);
            #1;
        end
        bus.in_valid = 1'b0;
        #1;
        if (bus.fifo_wr_en) begin
            push_t.push_back(8);
            push_d.push_back(bus.fifo_wr_data);
        end
        check("t5_npush", 64'(push_t.size()), 64'd2);
        if (push_t.size() == 2) begin
            check("t5_gap", 64'(push_t[1] - push_t[0]), 64'd4);
            check("t5_first", 64'(push_t[0]), 64'd4);
            check("t5_data0", 64'(push_d[0]), 64'({1'b0, 2'b11, b[3], b[2], b[1], b[0]}));
            check("t5_data1", 64'(push_d[1]), 64'({1'b0, 2'b11, b[7], b[6], b[5], b[4]}));
        end
        clk1();
        check("t5_cnt", 64'(word_cnt), 64'd6);

        // Reset mid-word
        beat(8'hC1, 0); beat(8'hC2, 0);
        wr_reset_n = 1'b0;
        #1;
        check("t6_wen", 64'(bus.fifo_wr_en), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_cnt", 64'(word_cnt), 64'd0);
        check("t6_data", 64'(bus.fifo_wr_data), 64'd0);
        clk1();
        wr_reset_n = 1'b1;
        clk1();
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) beat(b[i], 0);
        check("t6_wen2", 64'(bus.fifo_wr_en), 64'd1);
        check("t6_data2", 64'(bus.fifo_wr_data), 64'({1'b0, 2'b11, b[3], b[2], b[1], b[0]}));
        clk1();

        // Randomized traffic against the beat-list model
        wr_reset_n = 1'b0;
        clk1();
        wr_reset_n = 1'b1;
        clk1();
        staged      = 0;
        staged_word = '0;
        nonacc      = 0;
        model_cnt   = 0;
        q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            // Keep stalls short so the idle timer never expires here
            if (nonacc >= 3) begin
                v = 1;
                f = 0;
            end else begin
                v = ($urandom_range(0, 9) < 7);
                f = ($urandom_range(0, 3) == 0);
            end
            l = ($urandom_range(0, 5) == 0);
            d = 8'($urandom);
            bus.in_valid  = v;
            bus.in_data   = d;
            bus.in_last   = l;
            bus.fifo_full = f;
            #1;
            exp_ready = !(staged && f);
            exp_wen   = staged && !f;
            check("rnd_ready", 64'(bus.in_ready), 64'(exp_ready));
            check("rnd_wen", 64'(bus.fifo_wr_en), 64'(exp_wen));
            if (staged)
                check("rnd_data", 64'(bus.fifo_wr_data), 64'(staged_word));
            check("rnd_cnt", 64'(word_cnt), 64'(model_cnt));
            check("rnd_busy", 64'(busy), 64'((q.size() > 0) || staged));
            if (exp_wen) begin
                staged = 0;
                model_cnt++;
            end
            if (v && exp_ready) begin
                nonacc = 0;
                q.push_back(d);
                if ((q.size() == 4) || l) begin
                    staged_word = pack_q(q, l);
                    staged      = 1;
                    q.delete();
                end
            end else begin
                nonacc++;
            end
            @(posedge wr_clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
